// File: rtl/mem_stage_pkg.sv
// Shared widths, default timeout and wait-FSM state encoding for the MEM stage.
package mem_stage_pkg;

    localparam int WORD_LEN        = 32;
    localparam int REG_ADDR_LEN    = 5;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks one outstanding data-memory request and reports completion or bus timeout.
module mem_wait_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic dmem_req,
    input  logic dmem_ready,
    output logic done,
    output logic timeout_hit
);

    localparam int             CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;

    // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        timeout_hit  = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_next = MEM_WAIT;
                    w_cnt_next   = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                // A ready in the last allowed cycle wins over the timeout.
                if (dmem_ready) begin
                    w_state_next = MEM_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = MEM_IDLE;
                    w_cnt_next   = '0;
                    timeout_hit  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = MEM_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign done = ~dmem_req | dmem_ready | timeout_hit;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE/MEM register, data-memory handshake, MEM/WB register and stall.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_LEN     = mem_stage_pkg::WORD_LEN,
    parameter int REG_ADDR_LEN = mem_stage_pkg::REG_ADDR_LEN,
    parameter int TIMEOUT      = mem_stage_pkg::DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exe_valid,
    input  logic                    exe_mem_read,
    input  logic                    exe_mem_write,
    input  logic                    exe_wb_en,
    input  logic [REG_ADDR_LEN-1:0] exe_dest,
    input  logic [WORD_LEN-1:0]     ALU_Result,
    input  logic [WORD_LEN-1:0]     Store_Value,
    output logic                    stall,
    output logic [WORD_LEN-1:0]     ALU_Result_MEM,
    output logic [WORD_LEN-1:0]     Result_WB,
    output logic                    wb_valid,
    output logic                    wb_en,
    output logic [REG_ADDR_LEN-1:0] wb_dest,
    output logic                    exc_misalign,
    output logic                    exc_buserr,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [WORD_LEN-1:0]     dmem_addr,
    output logic [WORD_LEN-1:0]     dmem_wdata,
    input  logic [WORD_LEN-1:0]     dmem_rdata,
    input  logic                    dmem_ready
);

    logic                    r_m_valid, r_m_mem_read, r_m_mem_write, r_m_wb_en;
    logic [REG_ADDR_LEN-1:0] r_m_dest;
    logic [WORD_LEN-1:0]     r_alu_result, r_store_value;

    logic                    r_wb_valid, r_wb_en, r_exc_misalign, r_exc_buserr;
    logic [REG_ADDR_LEN-1:0] r_wb_dest;
    logic [WORD_LEN-1:0]     r_result_wb;

    logic w_mem_op, w_misalign, w_req, w_done, w_timeout_hit;

    assign w_mem_op   = r_m_valid & (r_m_mem_read | r_m_mem_write);
    assign w_misalign = w_mem_op & (r_alu_result[1:0] != 2'b00);
    assign w_req      = w_mem_op & ~w_misalign;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .dmem_req    (w_req),
        .dmem_ready  (dmem_ready),
        .done        (w_done),
        .timeout_hit (w_timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid     <= 1'b0;
            r_m_mem_read  <= 1'b0;
            r_m_mem_write <= 1'b0;
            r_m_wb_en     <= 1'b0;
            r_m_dest      <= '0;
            r_alu_result  <= '0;
            r_store_value <= '0;
        end else if (!stall) begin
            r_m_valid     <= exe_valid;
            r_m_mem_read  <= exe_mem_read;
            r_m_mem_write <= exe_mem_write;
            r_m_wb_en     <= exe_wb_en;
            r_m_dest      <= exe_dest;
            r_alu_result  <= ALU_Result;
            r_store_value <= Store_Value;
        end
    end

    // While an access is outstanding WB sees bubbles; Result_WB keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_en        <= 1'b0;
            r_wb_dest      <= '0;
            r_exc_misalign <= 1'b0;
            r_exc_buserr   <= 1'b0;
            r_result_wb    <= '0;
        end else if (w_done) begin
            r_wb_valid     <= r_m_valid;
            r_wb_en        <= r_m_valid & r_m_wb_en & ~w_misalign & ~w_timeout_hit;
            r_wb_dest      <= r_m_dest;
            r_exc_misalign <= w_misalign;
            r_exc_buserr   <= w_timeout_hit;
            r_result_wb    <= (r_m_mem_read & dmem_ready) ? dmem_rdata : r_alu_result;
        end else begin
            r_wb_valid     <= 1'b0;
            r_wb_en        <= 1'b0;
            r_exc_misalign <= 1'b0;
            r_exc_buserr   <= 1'b0;
        end
    end

    assign stall          = w_req & ~w_done;
    assign dmem_req       = w_req;
    assign dmem_we        = w_req & r_m_mem_write;
    assign dmem_addr      = {r_alu_result[WORD_LEN-1:2], 2'b00};
    assign dmem_wdata     = r_store_value;
    assign ALU_Result_MEM = r_alu_result;
    assign Result_WB      = r_result_wb;
    assign wb_valid       = r_wb_valid;
    assign wb_en          = r_wb_en;
    assign wb_dest        = r_wb_dest;
    assign exc_misalign   = r_exc_misalign;
    assign exc_buserr     = r_exc_buserr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized instruction stream.
module tb_mem_stage;

    localparam int W  = 32;
    localparam int RA = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          exe_valid, exe_mem_read, exe_mem_write, exe_wb_en;
    logic [RA-1:0] exe_dest;
    logic [W-1:0]  ALU_Result, Store_Value;
    logic          stall;
    logic [W-1:0]  ALU_Result_MEM, Result_WB;
    logic          wb_valid, wb_en;
    logic [RA-1:0] wb_dest;
    logic          exc_misalign, exc_buserr;
    logic          dmem_req, dmem_we;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ready;

    mem_stage #(
        .WORD_LEN     (W),
        .REG_ADDR_LEN (RA),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exe_valid      (exe_valid),
        .exe_mem_read   (exe_mem_read),
        .exe_mem_write  (exe_mem_write),
        .exe_wb_en      (exe_wb_en),
        .exe_dest       (exe_dest),
        .ALU_Result     (ALU_Result),
        .Store_Value    (Store_Value),
        .stall          (stall),
        .ALU_Result_MEM (ALU_Result_MEM),
        .Result_WB      (Result_WB),
        .wb_valid       (wb_valid),
        .wb_en          (wb_en),
        .wb_dest        (wb_dest),
        .exc_misalign   (exc_misalign),
        .exc_buserr     (exc_buserr),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ready     (dmem_ready)
    );

    always #5 clk = ~clk;

    // One instruction as seen by the memory stage, plus how many cycles memory waits before ready.
    typedef struct {
        logic          valid, rd, wr, wb;
        logic [RA-1:0] dest;
        logic [W-1:0]  alu, st;
        int            wait_n;
    } instr_t;

    instr_t       prog[$];
    instr_t       cur, drv;
    bit           have_drv;
    int           k;
    logic [W-1:0] exp_res;
    int           n_checks = 0;
    int           n_errors = 0;
    int           stall_cnt;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(logic v, logic r, logic w, logic b, logic [RA-1:0] d,
                                  logic [W-1:0] a, logic [W-1:0] s, int n);
        instr_t t;
        t.valid = v; t.rd = r; t.wr = w; t.wb = b;
        t.dest = d; t.alu = a; t.st = s; t.wait_n = n;
        return t;
    endfunction

    function automatic instr_t zero_instr();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 0);
    endfunction

    function automatic instr_t rand_instr(logic v);
        int     ty, p;
        logic [1:0] lo;
        ty = $urandom_range(0, 9);
        p  = $urandom_range(0, 19);
        lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return mk(v, (ty >= 4 && ty <= 6), (ty >= 7), 1'($urandom), RA'($urandom),
                  {24'h0, 6'($urandom), lo}, $urandom,
                  (p == 0) ? TO - 1 : (p == 1) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3));
    endfunction

    // One clock of stimulus and checking; entered and left just after a rising edge.
    task automatic cycle();
        logic         req_e, mis_e, rdy, to, done;
        logic [W-1:0] rd_val;
        if (!have_drv) begin
            if (prog.size() != 0) drv = prog.pop_front();
            else                  drv = rand_instr(1'b0);
            have_drv = 1'b1;
        end
        exe_valid     = drv.valid;
        exe_mem_read  = drv.rd;
        exe_mem_write = drv.wr;
        exe_wb_en     = drv.wb;
        exe_dest      = drv.dest;
        ALU_Result    = drv.alu;
        Store_Value   = drv.st;

        req_e  = cur.valid && (cur.rd || cur.wr) && (cur.alu[1:0] == 2'b00);
        mis_e  = cur.valid && (cur.rd || cur.wr) && (cur.alu[1:0] != 2'b00);
        rdy    = req_e && (k == cur.wait_n);
        to     = req_e && !rdy && (k == TO - 1);
        done   = !req_e || rdy || to;
        rd_val = $urandom;
        dmem_ready = rdy;
        dmem_rdata = rd_val;

        @(negedge clk);
        check("stall", W'(stall), W'(!done));
        check("dmem_req", W'(dmem_req), W'(req_e));
        if (req_e) begin
            check("dmem_addr", dmem_addr, {cur.alu[W-1:2], 2'b00});
            check("dmem_we", W'(dmem_we), W'(cur.wr));
            check("dmem_wdata", dmem_wdata, cur.st);
        end
        check("alu_result_mem", ALU_Result_MEM, cur.alu);
        if (stall) stall_cnt++;

        @(posedge clk);
        #1;
        if (done) begin
            exp_res = (cur.rd && rdy) ? rd_val : cur.alu;
            check("wb_valid", W'(wb_valid), W'(cur.valid));
            check("wb_dest", W'(wb_dest), W'(cur.dest));
            check("exc_misalign", W'(exc_misalign), W'(mis_e));
            check("exc_buserr", W'(exc_buserr), W'(to));
            check("wb_en", W'(wb_en), W'(cur.valid && cur.wb && !mis_e && !to));
            cur      = drv;
            have_drv = 1'b0;
            k        = 0;
        end else begin
            check("bubble_wb_valid", W'(wb_valid), '0);
            check("bubble_wb_en", W'(wb_en), '0);
            check("bubble_exc", W'({exc_misalign, exc_buserr}), '0);
            k++;
        end
        check("result_wb", Result_WB, exp_res);
    endtask

    task automatic drain();
        int guard = 0;
        do begin
            cycle();
            guard++;
        end while ((prog.size() != 0 || cur.valid) && guard < 4000);
        if (guard >= 4000) check("drain_bound", W'(guard), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, W'(stall), '0);
        check({tag, "_dmem_req"}, W'(dmem_req), '0);
        check({tag, "_dmem_we"}, W'(dmem_we), '0);
        check({tag, "_dmem_addr"}, dmem_addr, '0);
        check({tag, "_dmem_wdata"}, dmem_wdata, '0);
        check({tag, "_alu_mem"}, ALU_Result_MEM, '0);
        check({tag, "_result_wb"}, Result_WB, '0);
        check({tag, "_wb_flags"}, W'({wb_valid, wb_en, exc_misalign, exc_buserr}), '0);
        check({tag, "_wb_dest"}, W'(wb_dest), '0);
    endtask

    // Reset is asserted asynchronously; zeroed inputs make the first post-release load a zero bubble.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        exe_valid = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_wb_en = 1'b0;
        exe_dest = '0; ALU_Result = '0; Store_Value = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur      = zero_instr();
        drv      = zero_instr();
        have_drv = 1'b0;
        k        = 0;
        exp_res  = '0;
        prog.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        exe_valid = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_wb_en = 1'b0;
        exe_dest = '0; ALU_Result = '0; Store_Value = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        #2;
        do_reset("por");

        // Load to 0x10 held waiting for three cycles, then reset mid-access.
        prog.push_back(mk(1, 1, 0, 1, 5'd3, 32'h10, 32'h0, 1000));
        repeat (4) cycle();
        check("midwait_req_before_rst", W'(dmem_req), W'(1));
        do_reset("midwait");
        stall_cnt = 0;
        repeat (4) cycle();
        check("post_rst_stalls", W'(stall_cnt), '0);

        // ALU op straight through.
        stall_cnt = 0;
        prog.push_back(mk(1, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 0));
        drain();
        check("alu_op_stalls", W'(stall_cnt), '0);

        // Zero-wait load.
        stall_cnt = 0;
        prog.push_back(mk(1, 1, 0, 1, 5'd7, 32'h40, 32'h0, 0));
        drain();
        check("load0_stalls", W'(stall_cnt), '0);

        // Load with three wait cycles.
        stall_cnt = 0;
        prog.push_back(mk(1, 1, 0, 1, 5'd8, 32'h44, 32'h0, 3));
        drain();
        check("load3_stalls", W'(stall_cnt), W'(3));

        // Misaligned store.
        stall_cnt = 0;
        prog.push_back(mk(1, 0, 1, 1, 5'd2, 32'h46, 32'hCAFE_F00D, 0));
        drain();
        check("misalign_stalls", W'(stall_cnt), '0);

        // Memory never answers: bus error after TIMEOUT-1 stall cycles.
        stall_cnt = 0;
        prog.push_back(mk(1, 1, 0, 1, 5'd9, 32'h48, 32'h0, 1000));
        drain();
        check("timeout_stalls", W'(stall_cnt), W'(TO - 1));

        // Ready in the timeout cycle is a success.
        stall_cnt = 0;
        prog.push_back(mk(1, 1, 0, 1, 5'd10, 32'h4C, 32'h0, TO - 1));
        drain();
        check("edge_ready_stalls", W'(stall_cnt), W'(TO - 1));

        // Back-to-back loads, one ready pulse each.
        stall_cnt = 0;
        prog.push_back(mk(1, 1, 0, 1, 5'd11, 32'h0, 32'h0, 1));
        prog.push_back(mk(1, 1, 0, 1, 5'd12, 32'h4, 32'h0, 1));
        drain();
        check("b2b_stalls", W'(stall_cnt), W'(2));

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) prog.push_back(rand_instr(1'($urandom_range(0, 9) != 0)));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-stage outputs (ALU result, store value, control) into the EXE/MEM register.
- Performs the data-memory access over a ready/request handshake, and registers the outcome into the MEM/WB register.
- Drives the MEM- and WB-side forwarding values back to the execute stage, and produces a pipeline stall while a memory access is outstanding.

Parameters:
- WORD_LEN, 32, datapath width (matches `WORD_LEN).
- REG_ADDR_LEN, 5, destination register index width.
- TIMEOUT, 16, cycles a request may wait for dmem_ready before a bus error is declared (≥2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- exe_valid  in  1  execute-stage instruction valid
- exe_mem_read  in  1  instruction is a load
- exe_mem_write  in  1  instruction is a store
- exe_wb_en  in  1  instruction writes a register
- exe_dest  in  REG_ADDR_LEN  destination register
- ALU_Result  in  WORD_LEN  execute-stage result / memory address
- Store_Value  in  WORD_LEN  forwarded store data
- stall  out  1  freeze IF/ID/EXE and hold EXE/MEM register
- ALU_Result_MEM  out  WORD_LEN  EXE/MEM registered ALU result (forwarding source)
- Result_WB  out  WORD_LEN  MEM/WB registered result (forwarding source)
- wb_valid  out  1  MEM/WB valid
- wb_en  out  1  MEM/WB register-write enable
- wb_dest  out  REG_ADDR_LEN  MEM/WB destination
- exc_misalign  out  1  MEM/WB: access address not word-aligned
- exc_buserr  out  1  MEM/WB: memory did not respond within TIMEOUT
- dmem_req  out  1  memory request
- dmem_we  out  1  write strobe (valid with dmem_req)
- dmem_addr  out  WORD_LEN  {ALU_Result_MEM[WORD_LEN-1:2],2'b00}
- dmem_wdata  out  WORD_LEN  registered store value
- dmem_rdata  in  WORD_LEN  load data, valid when dmem_ready=1
- dmem_ready  in  1  access complete this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. While rst=1, all registers clear immediately:
  - every output = 0, including dmem_req and stall
  - FSM returns to IDLE; wait counter = 0
  - an in-flight access is abandoned and never completes
- EXE/MEM register: loads all exe_* inputs, ALU_Result and Store_Value on a clock edge when stall=0; holds when stall=1. exe_valid=0 loads a bubble (m_valid=0).
- mem_op = m_valid & (m_mem_read | m_mem_write).
- Alignment: m_misalign = mem_op & (ALU_Result_MEM[1:0] != 0). A misaligned op never asserts dmem_req and completes in one cycle.
- Requests: dmem_req = mem_op & ~m_misalign; dmem_we = dmem_req & m_mem_write.
- FSM, states IDLE and WAIT:
  - IDLE, dmem_req=1, dmem_ready=1: complete, stay IDLE.
  - IDLE, dmem_req=1, dmem_ready=0: go to WAIT, cnt=1.
  - WAIT, dmem_ready=1: complete, go to IDLE, cnt=0.
  - WAIT, dmem_ready=0, cnt=TIMEOUT-1: complete with bus error, go to IDLE, cnt=0.
  - WAIT otherwise: cnt+1.
  - Counter width = $clog2(TIMEOUT).
- done = ~dmem_req | dmem_ready | timeout_hit.
- stall = dmem_req & ~done. This is combinational from dmem_ready, which is intentional: a zero-wait memory costs no stall.
- MEM/WB register loads every edge where done=1:
  - wb_valid = m_valid
  - wb_dest = m_dest
  - Result_WB = dmem_rdata if (m_mem_read & dmem_ready), else ALU_Result_MEM
  - exc_misalign = m_misalign
  - exc_buserr = timeout_hit
  - wb_en = m_valid & m_wb_en & ~exc_misalign_next & ~exc_buserr_next
- When done=0, the MEM/WB register loads a bubble: wb_valid=0, wb_en=0, both exception flags 0, Result_WB held.
- Latency:
  - non-memory instruction: EXE→WB outputs in 2 edges
  - memory op with N wait cycles: 2+N edges
  - bus error: 2+TIMEOUT-1 edges
- Simultaneous events:
  - dmem_ready arriving in the timeout cycle counts as success; no bus error.
  - Stores complete on dmem_ready; dmem_rdata is ignored.
  - A load with wb_en=0 still accesses memory.
- Back-to-back memory ops: the next op is presented on the edge after completion. dmem_req may stay high continuously across the two ops; each ready pulse retires exactly one op.

Decomposition:
- Shared package/defines: WORD_LEN, REG_ADDR_LEN, FSM state encodings (MEM_IDLE, MEM_WAIT), default TIMEOUT.
- One natural sub-module: mem_wait_fsm. It contains the FSM plus the timeout counter; inputs dmem_req, dmem_ready; outputs done, timeout_hit.
- Both pipeline registers stay in mem_stage.

Test Plan:
- Reset mid-wait: issue load to 0x10, hold dmem_ready=0 for 3 cycles, assert rst → dmem_req, stall and all outputs 0 immediately; after release, FSM is IDLE with no stale completion.
- ALU op through: exe_valid=1, wb_en=1, dest=5, ALU_Result=0x1234 → ALU_Result_MEM=0x1234 after edge 1; Result_WB=0x1234, wb_en=1, wb_dest=5 after edge 2; stall never asserted.
- Load with zero wait: addr 0x40, dmem_ready tied 1, rdata 0xDEADBEEF → stall stays 0; Result_WB=0xDEADBEEF two edges after issue.
- Load with 3 wait cycles: addr 0x44 → stall high exactly 3 cycles, EXE/MEM register held throughout; Result_WB=rdata; dmem_addr=0x44 stable across all request cycles.
- Misaligned store: addr 0x46 → dmem_req never high; exc_misalign=1, wb_en=0, no stall.
- Timeout and boundary: TIMEOUT=16, dmem_ready never asserted → stall for 15 cycles, then exc_buserr=1, wb_en=0. Repeat with ready asserted in cycle 15 → success, exc_buserr=0. Then back-to-back loads to 0x0 and 0x4 with single ready pulses → two WB results in order, no duplicates.
